// File: rtl/q_table_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : q_pkg
// Desc     : Shared types and constants for the Q-table controller and the
//            Bellman updater datapath (state encoding, widths, LFSR setup).
// Revision : 1.0 - initial release
// ============================================================================
package q_pkg;

    localparam int Q_W     = 32;                // Q-value / reward width
    localparam int A_W     = 2;                 // action index width
    localparam int NUM_ACT = 4;                 // actions (= banks)

    // Fibonacci LFSR, taps 16,14,13,11: feedback is the XOR of bits 0,2,3,5
    // of the current state, shifted in at the top while the word moves right.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_RD_S  = 3'd2,
        ST_RD_N  = 3'd3,
        ST_BEAT1 = 3'd4,
        ST_WAIT  = 3'd5,
        ST_WR    = 3'd6
    } state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {^(cur & LFSR_TAPS), cur[15:1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/q_table_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : q_table_ctrl_if
// Desc      : Request handshake plus updater operand/result bus of the
//             Q-table controller. master = requester/updater side,
//             slave = controller side.
// Revision  : 1.0 - initial release
// ============================================================================
interface q_table_ctrl_if
    import q_pkg::*;
#(
    parameter int NUM_STATES = 64
);
    localparam int SW = $clog2(NUM_STATES);

    logic                  start;
    logic                  ready;
    logic [SW-1:0]         s_cur;
    logic [SW-1:0]         s_next;
    logic [A_W-1:0]        a_cur;
    logic signed [Q_W-1:0] reward;
    logic [7:0]            epsilon;
    logic signed [Q_W-1:0] upd_q0;
    logic signed [Q_W-1:0] upd_q1;
    logic signed [Q_W-1:0] upd_q2;
    logic signed [Q_W-1:0] upd_q3;
    logic [A_W-1:0]        upd_a;
    logic [A_W-1:0]        upd_amax;
    logic signed [Q_W-1:0] upd_r;
    logic signed [Q_W-1:0] upd_qnew;
    logic                  done;
    logic [A_W-1:0]        act;

    modport master (
        output start, s_cur, s_next, a_cur, reward, epsilon, upd_qnew,
        input  ready, upd_q0, upd_q1, upd_q2, upd_q3, upd_a, upd_amax,
               upd_r, done, act
    );

    modport slave (
        input  start, s_cur, s_next, a_cur, reward, epsilon, upd_qnew,
        output ready, upd_q0, upd_q1, upd_q2, upd_q3, upd_a, upd_amax,
               upd_r, done, act
    );

endinterface
`default_nettype wire

// File: rtl/q_table_ctrl_argmax4.sv
`default_nettype none
// ============================================================================
// Module   : q_argmax4
// Desc     : Combinational signed argmax over four Q values; ties resolve to
//            the lowest index.
// Revision : 1.0 - initial release
// ============================================================================
module q_argmax4
    import q_pkg::*;
(
    input  wire logic signed [Q_W-1:0] i_q0,
    input  wire logic signed [Q_W-1:0] i_q1,
    input  wire logic signed [Q_W-1:0] i_q2,
    input  wire logic signed [Q_W-1:0] i_q3,
    output logic [A_W-1:0]             o_idx
);

    logic signed [Q_W-1:0] w_best;

    // Strict greater-than keeps the earlier index on equal values
    always_comb begin
        w_best = i_q0;
        o_idx  = 2'd0;
        if (i_q1 > w_best) begin
            w_best = i_q1;
            o_idx  = 2'd1;
        end
        if (i_q2 > w_best) begin
            w_best = i_q2;
            o_idx  = 2'd2;
        end
        if (i_q3 > w_best) begin
            w_best = i_q3;
            o_idx  = 2'd3;
        end
    end

endmodule
`default_nettype wire

// File: rtl/q_table_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : q_table_ctrl
// Desc     : Q-table storage and sequencing for one agent: fetches rows s and
//            s', streams the two-beat operand sequence to the updater, writes
//            the result back to Q(s,a) and picks an epsilon-greedy action.
// Revision : 1.0 - initial release
// ============================================================================
module q_table_ctrl
    import q_pkg::*;
#(
    parameter int NUM_STATES  = 64,
    parameter int UPD_LATENCY = 4
)(
    input  wire logic       clk,
    input  wire logic       rst,
    q_table_ctrl_if.slave   bus
);

    localparam int SW = $clog2(NUM_STATES);
    localparam int CW = $clog2(UPD_LATENCY + 1);

    state_t                state_q, state_d;
    logic [SW-1:0]         init_idx_q, init_idx_d;
    logic [CW-1:0]         wait_cnt_q, wait_cnt_d;

    logic [SW-1:0]         s_q, s_d;
    logic [SW-1:0]         sn_q, sn_d;
    logic [A_W-1:0]        a_q, a_d;
    logic [7:0]            eps_q, eps_d;
    logic signed [Q_W-1:0] upd_r_q, upd_r_d;
    logic [15:0]           lfsr_q, lfsr_d;
    logic [A_W-1:0]        choice_q, choice_d;
    logic [A_W-1:0]        act_q, act_d;
    logic [A_W-1:0]        upd_a_q, upd_a_d;
    logic [A_W-1:0]        upd_amax_q, upd_amax_d;

    logic [NUM_ACT-1:0]    w_we;
    logic [SW-1:0]         w_waddr;
    logic signed [Q_W-1:0] w_wdata;
    logic                  w_re;
    logic [SW-1:0]         w_raddr;
    logic signed [Q_W-1:0] w_row [NUM_ACT];
    logic [A_W-1:0]        w_amax;
    logic                  w_accept;
    logic                  w_explore;

    assign w_accept  = (state_q == ST_IDLE) && bus.start;
    assign w_explore = (lfsr_q[7:0] < eps_q);

    // One bank per action; the bank's read register doubles as the
    // upd_q lane so the beat shown is the row fetched the cycle before.
    for (genvar b = 0; b < NUM_ACT; b++) begin : g_bank
        logic signed [Q_W-1:0] mem [NUM_STATES];
        logic signed [Q_W-1:0] rd_q;

        // Single write port: INIT clearing or write-back of Q(s,a)
        always_ff @(posedge clk) begin
            if (w_we[b]) begin
                mem[w_waddr] <= w_wdata;
            end
        end

        // Synchronous row read, loaded only in the two fetch states
        always_ff @(posedge clk) begin
            if (rst) begin
                rd_q <= '0;
            end else if (w_re) begin
                rd_q <= mem[w_raddr];
            end
        end

        assign w_row[b] = rd_q;
    end

    q_argmax4 u_argmax (
        .i_q0  (w_row[0]),
        .i_q1  (w_row[1]),
        .i_q2  (w_row[2]),
        .i_q3  (w_row[3]),
        .o_idx (w_amax)
    );

    // FSM state register with init-row and latency counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            init_idx_q <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state logic; a latency of 1 skips WAIT entirely
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_INIT: begin
                init_idx_d = init_idx_q + 1'b1;
                if (init_idx_q == SW'(NUM_STATES - 1)) begin
                    init_idx_d = '0;
                    state_d    = ST_IDLE;
                end
            end
            ST_IDLE:  if (bus.start) state_d = ST_RD_S;
            ST_RD_S:  state_d = ST_RD_N;
            ST_RD_N:  state_d = ST_BEAT1;
            ST_BEAT1: begin
                wait_cnt_d = '0;
                state_d    = (UPD_LATENCY <= 1) ? ST_WR : ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_cnt_q == CW'(UPD_LATENCY - 2)) begin
                    state_d = ST_WR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_WR:    state_d = ST_IDLE;
            default:  state_d = ST_INIT;
        endcase
    end

    // Transaction datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q        <= '0;
            sn_q       <= '0;
            a_q        <= '0;
            eps_q      <= '0;
            upd_r_q    <= '0;
            lfsr_q     <= LFSR_SEED;
            choice_q   <= '0;
            act_q      <= '0;
            upd_a_q    <= '0;
            upd_amax_q <= '0;
        end else begin
            s_q        <= s_d;
            sn_q       <= sn_d;
            a_q        <= a_d;
            eps_q      <= eps_d;
            upd_r_q    <= upd_r_d;
            lfsr_q     <= lfsr_d;
            choice_q   <= choice_d;
            act_q      <= act_d;
            upd_a_q    <= upd_a_d;
            upd_amax_q <= upd_amax_d;
        end
    end

    // Latch request on accept, decide action in BEAT1, publish it in WR
    always_comb begin
        s_d        = s_q;
        sn_d       = sn_q;
        a_d        = a_q;
        eps_d      = eps_q;
        upd_r_d    = upd_r_q;
        choice_d   = choice_q;
        act_d      = act_q;
        upd_a_d    = upd_a_q;
        upd_amax_d = upd_amax_q;
        lfsr_d     = lfsr_next(lfsr_q);
        if (w_accept) begin
            s_d     = bus.s_cur;
            sn_d    = bus.s_next;
            a_d     = bus.a_cur;
            eps_d   = bus.epsilon;
            upd_r_d = bus.reward;
        end
        if (state_q == ST_BEAT1) begin
            choice_d   = w_explore ? lfsr_q[9:8] : w_amax;
            upd_a_d    = a_q;
            upd_amax_d = w_amax;
        end
        if (state_q == ST_WR) begin
            act_d = choice_q;
        end
    end

    // Outputs and memory port controls decoded from the current state
    always_comb begin
        bus.ready    = (state_q == ST_IDLE);
        bus.done     = (state_q == ST_WR);
        bus.act      = (state_q == ST_WR) ? choice_q : act_q;
        bus.upd_a    = (state_q == ST_BEAT1) ? a_q : upd_a_q;
        bus.upd_amax = (state_q == ST_BEAT1) ? w_amax : upd_amax_q;
        bus.upd_r    = upd_r_q;
        bus.upd_q0   = w_row[0];
        bus.upd_q1   = w_row[1];
        bus.upd_q2   = w_row[2];
        bus.upd_q3   = w_row[3];

        w_re    = (state_q == ST_RD_S) || (state_q == ST_RD_N);
        w_raddr = (state_q == ST_RD_S) ? s_q : sn_q;

        // A write-back coinciding with rst is dropped; INIT re-clears anyway
        w_we    = '0;
        w_waddr = s_q;
        w_wdata = bus.upd_qnew;
        if (!rst) begin
            if (state_q == ST_INIT) begin
                w_we    = '1;
                w_waddr = init_idx_q;
                w_wdata = '0;
            end else if (state_q == ST_WR) begin
                w_we[a_q] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_q_table_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_q_table_ctrl
// Desc     : Self-checking bench for q_table_ctrl: table-driven transactions,
//            randomized transactions against a Q-table/LFSR reference model,
//            and hand-written reset/held-start sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_q_table_ctrl;
    import q_pkg::*;

    localparam int NS   = 64;
    localparam int LAT  = 4;
    localparam int SW   = $clog2(NS);
    localparam int LSEQ = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    int          qm [NS][4];
    logic [15:0] lfsr_seq [LSEQ];

    q_table_ctrl_if #(.NUM_STATES(NS)) bus ();

    q_table_ctrl #(.NUM_STATES(NS), .UPD_LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // cycles since the last edge that saw rst high
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int s; int sn; int a; int r; int eps; int qnew;
        int exp_amax; int exp_act;   // -1: take from the reference model
    } vec_t;

    task automatic chk(input string name, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int amax4(input int v[4]);
        int b = 0;
        for (int i = 1; i < 4; i++) if (v[i] > v[b]) b = i;
        return b;
    endfunction

    task automatic chk_reset_outputs();
        chk("rst_ready", bus.ready, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_act", bus.act, 0);
        chk("rst_q0", bus.upd_q0, 0);
        chk("rst_q1", bus.upd_q1, 0);
        chk("rst_q2", bus.upd_q2, 0);
        chk("rst_q3", bus.upd_q3, 0);
        chk("rst_upd_a", bus.upd_a, 0);
        chk("rst_upd_amax", bus.upd_amax, 0);
        chk("rst_upd_r", bus.upd_r, 0);
    endtask

    // Release reset (caller is at a negedge with rst high) and time INIT
    task automatic release_and_wait_init();
        int n = 0;
        int seen_done = 0;
        rst = 1'b0;
        while (bus.ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen_done = 1;
            n++;
        end
        chk("init_cycles", n, NS);
        chk("init_no_done", seen_done, 0);
        for (int i = 0; i < NS; i++) for (int j = 0; j < 4; j++) qm[i][j] = 0;
    endtask

    // One full transaction; cont=1 means start is already high in IDLE,
    // hold=1 leaves start asserted after the accept.
    task automatic txn(input int s, input int sn, input int a, input int r,
                       input int eps, input int qnew, input int exp_amax,
                       input int exp_act, input bit cont, input bit hold);
        int row_s[4];
        int row_n[4];
        int am;
        int ex_act;
        int n;
        logic [15:0] l;
        row_s = qm[s];
        row_n = qm[sn];
        if (!cont) begin
            n = 0;
            while (bus.ready !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("ready_before_start", bus.ready, 1);
            bus.start   = 1'b1;
            bus.s_cur   = SW'(s);
            bus.s_next  = SW'(sn);
            bus.a_cur   = 2'(a);
            bus.reward  = r;
            bus.epsilon = 8'(eps);
        end else begin
            chk("held_start_ready", bus.ready, 1);
        end
        @(negedge clk);                       // C1
        if (!hold) bus.start = 1'b0;
        chk("c1_ready", bus.ready, 0);
        chk("c1_done", bus.done, 0);
        @(negedge clk);                       // C2: beat 0
        chk("beat0_q0", bus.upd_q0, row_s[0]);
        chk("beat0_q1", bus.upd_q1, row_s[1]);
        chk("beat0_q2", bus.upd_q2, row_s[2]);
        chk("beat0_q3", bus.upd_q3, row_s[3]);
        @(negedge clk);                       // C3: beat 1
        chk("beat1_q0", bus.upd_q0, row_n[0]);
        chk("beat1_q1", bus.upd_q1, row_n[1]);
        chk("beat1_q2", bus.upd_q2, row_n[2]);
        chk("beat1_q3", bus.upd_q3, row_n[3]);
        am = (exp_amax >= 0) ? exp_amax : amax4(row_n);
        chk("beat1_amax", bus.upd_amax, am);
        chk("beat1_a", bus.upd_a, a);
        chk("beat1_r", bus.upd_r, r);
        if (cyc >= LSEQ) begin
            chk("lfsr_table_range", cyc, 0);
            l = '0;
        end else begin
            l = lfsr_seq[cyc];
        end
        ex_act = (int'(l[7:0]) < eps) ? int'(l[9:8]) : am;
        if (exp_act >= 0) ex_act = exp_act;
        for (int i = 1; i < LAT; i++) begin    // WAIT
            @(negedge clk);
            chk("wait_done", bus.done, 0);
            chk("wait_amax_hold", bus.upd_amax, am);
        end
        @(negedge clk);                       // C3+LAT: write-back
        bus.upd_qnew = qnew;
        chk("wr_done", bus.done, 1);
        chk("wr_act", bus.act, ex_act);
        qm[s][a] = qnew;
        @(negedge clk);                       // back in IDLE
        bus.upd_qnew = int'($urandom);
        chk("idle_done", bus.done, 0);
        chk("idle_ready", bus.ready, 1);
        chk("idle_act_hold", bus.act, ex_act);
        chk("idle_r_hold", bus.upd_r, r);
    endtask

    vec_t vt[$];

    initial begin
        int e;
        lfsr_seq[0] = LFSR_SEED;
        for (int i = 1; i < LSEQ; i++) begin
            logic [15:0] p;
            p = lfsr_seq[i-1];
            lfsr_seq[i] = {p[0] ^ p[2] ^ p[3] ^ p[5], p[15:1]};
        end

        bus.start = 1'b0; bus.s_cur = '0; bus.s_next = '0; bus.a_cur = '0;
        bus.reward = '0; bus.epsilon = '0; bus.upd_qnew = 32'h5A5A5A5A;

        // ---- reset state and INIT length
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        release_and_wait_init();

        // ---- table-driven transactions
        //        s   sn  a   r    eps  qnew     amax act
        vt.push_back('{63,  0, 3,  -5,   0,   17,     -1, -1});
        vt.push_back('{ 5,  6, 0,   1,   0,   10,     -1, -1});
        vt.push_back('{ 5,  6, 1,   1,   0,   40,     -1, -1});
        vt.push_back('{ 5,  6, 2,   1,   0,   40,     -1, -1});
        vt.push_back('{ 5,  6, 3,   1,   0,   -7,     -1, -1});
        vt.push_back('{ 3,  5, 2, 100,   0, 'h1234,    1,  1});
        vt.push_back('{ 3, 63, 0,   2,   0,   -1,     -1, -1});
        vt.push_back('{ 7,  8, 0,   0,   0,    1,     -1, -1});
        vt.push_back('{ 7,  8, 1,   0,   0,    2,     -1, -1});
        vt.push_back('{ 7,  8, 2,   0,   0,    3,     -1, -1});
        vt.push_back('{ 7,  8, 3,   0,   0,    4,     -1, -1});
        vt.push_back('{ 7,  7, 0,  -9,   0,   99,      3,  3});
        vt.push_back('{ 7,  7, 1,   3,   0,    2,     -1, -1});
        vt.push_back('{20,  5, 1,   4, 255,  -50,     -1, -1});
        vt.push_back('{21,  7, 2,   4, 255,   60,     -1, -1});
        foreach (vt[i])
            txn(vt[i].s, vt[i].sn, vt[i].a, vt[i].r, vt[i].eps, vt[i].qnew,
                vt[i].exp_amax, vt[i].exp_act, 1'b0, 1'b0);

        // ---- randomized transactions against the model
        for (int k = 0; k < 30; k++) begin
            case ($urandom_range(0, 2))
                0:       e = 0;
                1:       e = 255;
                default: e = int'($urandom_range(0, 255));
            endcase
            txn(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 3)), int'($urandom),
                e, int'($urandom) >>> 8, -1, -1, 1'b0, 1'b0);
        end

        // ---- start held through WAIT/WR: exactly one accept per IDLE cycle
        txn(2, 9, 3, 7, 128, 111, -1, -1, 1'b0, 1'b1);
        txn(2, 9, 3, 7, 128, 222, -1, -1, 1'b1, 1'b0);

        // ---- rst during WAIT discards the write-back and re-clears
        @(negedge clk);
        bus.start = 1'b1; bus.s_cur = SW'(10); bus.s_next = SW'(11);
        bus.a_cur = 2'd1; bus.reward = 5; bus.epsilon = 8'd0;
        @(negedge clk);                       // C1
        bus.start = 1'b0;
        @(negedge clk);                       // C2
        @(negedge clk);                       // C3
        @(negedge clk);                       // C4, WAIT
        rst = 1'b1;
        bus.upd_qnew = 32'h0000DEAD;
        @(negedge clk);
        chk_reset_outputs();
        release_and_wait_init();
        txn(10, 7, 0, 0, 0, 1, -1, -1, 1'b0, 1'b0);
        txn( 5, 3, 2, 0, 0, 1, -1, -1, 1'b0, 1'b0);
        txn(10, 7, 1, 0, 0, 1, -1, -1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
